// File: rtl/fme_pkg.sv
// Shared definitions for the best-candidate SAD search.
// Holds the candidate count, default widths and the control FSM state type.
package fme_pkg;

  localparam int unsigned NCAND         = 9;
  localparam int unsigned DEF_DATAWIDTH = 8;
  localparam int unsigned DEF_NSAMPLES  = 64;
  localparam int unsigned DEF_SADWIDTH  = 14;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_COMPARE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/sad_acc.sv
// One absolute-difference accumulator: sum += |b - a| per accepted sample.
// Ports:
//   clock, reset  - clock and synchronous active-high reset
//   enable        - global advance; low holds the sum
//   clr           - clear the sum (start of block)
//   acc_en        - add this cycle's absolute difference
//   a, b          - unsigned pixels (original, candidate)
//   sum           - registered running SAD
module sad_acc #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned SADWIDTH  = 14
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clr,
  input  logic                 acc_en,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic [SADWIDTH-1:0]  sum
);

  logic [DATAWIDTH-1:0] diff_c;

  // Absolute difference without a sign bit: subtract the smaller from the larger.
  always_comb begin
    diff_c = '0;
    if (b > a) diff_c = b - a;
    else       diff_c = a - b;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sum <= '0;
    end else if (enable) begin
      if (clr)         sum <= '0;
      else if (acc_en) sum <= sum + SADWIDTH'(diff_c);
    end
  end

endmodule

// File: rtl/sad_best_candidate.sv
// Accumulates SAD of nine candidate blocks against an original block, then
// scans the nine sums (one per cycle) and reports the lowest.
// Optional feature macro: FME_CENTER_BIAS_EN seeds the search with candidate 4
// (ties resolve to the centre); otherwise candidate 0 seeds (ties -> lowest).
// Ports:
//   clock, reset      - clock and synchronous active-high reset
//   enable            - global advance; low holds all state
//   start             - begin a new block (accepted only in IDLE)
//   in_valid          - orig/cand_* form a sample this cycle (used only in ACCUM)
//   orig, cand_0..8   - unsigned pixels
//   best_idx/best_sad - winning candidate and its SAD, held until next result
//   done              - one-cycle pulse with a new result
//   busy              - high while accumulating or comparing
module sad_best_candidate
  import fme_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DEF_DATAWIDTH,
  parameter int unsigned NSAMPLES  = DEF_NSAMPLES,
  parameter int unsigned SADWIDTH  = DEF_SADWIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [DATAWIDTH-1:0] orig,
  input  logic [DATAWIDTH-1:0] cand_0,
  input  logic [DATAWIDTH-1:0] cand_1,
  input  logic [DATAWIDTH-1:0] cand_2,
  input  logic [DATAWIDTH-1:0] cand_3,
  input  logic [DATAWIDTH-1:0] cand_4,
  input  logic [DATAWIDTH-1:0] cand_5,
  input  logic [DATAWIDTH-1:0] cand_6,
  input  logic [DATAWIDTH-1:0] cand_7,
  input  logic [DATAWIDTH-1:0] cand_8,
  output logic [3:0]           best_idx,
  output logic [SADWIDTH-1:0]  best_sad,
  output logic                 done,
  output logic                 busy
);

  localparam int unsigned CNTW = $clog2(NSAMPLES) + 1;

`ifdef FME_CENTER_BIAS_EN
  localparam logic [3:0] SEED_IDX = 4'd4;
`else
  localparam logic [3:0] SEED_IDX = 4'd0;
`endif

  // Worst-case sum must fit so the accumulators never wrap.
  if ((64'(NSAMPLES) * ((64'd1 << DATAWIDTH) - 64'd1)) >= (64'd1 << SADWIDTH)) begin : g_width_check
    $error("SADWIDTH too small for NSAMPLES*(2^DATAWIDTH-1)");
  end

  state_t               state;
  logic [CNTW-1:0]      sample_cnt;
  logic [3:0]           cmp_idx;
  logic [3:0]           cur_idx;
  logic [SADWIDTH-1:0]  cur_sad;

  logic [DATAWIDTH-1:0] cand_arr [NCAND];
  logic [SADWIDTH-1:0]  acc      [NCAND];

  logic                 clr_c;
  logic                 acc_en_c;
  logic [SADWIDTH-1:0]  cand_sad_c;
  logic [SADWIDTH-1:0]  base_sad_c;
  logic [3:0]           base_idx_c;
  logic [SADWIDTH-1:0]  nxt_sad_c;
  logic [3:0]           nxt_idx_c;

  assign cand_arr[0] = cand_0;
  assign cand_arr[1] = cand_1;
  assign cand_arr[2] = cand_2;
  assign cand_arr[3] = cand_3;
  assign cand_arr[4] = cand_4;
  assign cand_arr[5] = cand_5;
  assign cand_arr[6] = cand_6;
  assign cand_arr[7] = cand_7;
  assign cand_arr[8] = cand_8;

  // Accumulator controls.
  always_comb begin
    clr_c    = 1'b0;
    acc_en_c = 1'b0;
    if (enable && (state == ST_IDLE) && start)     clr_c    = 1'b1;
    if (enable && (state == ST_ACCUM) && in_valid) acc_en_c = 1'b1;
  end

  for (genvar k = 0; k < int'(NCAND); k++) begin : g_acc
    sad_acc #(
      .DATAWIDTH (DATAWIDTH),
      .SADWIDTH  (SADWIDTH)
    ) u_sad_acc (
      .clock  (clock),
      .reset  (reset),
      .enable (enable),
      .clr    (clr_c),
      .acc_en (acc_en_c),
      .a      (orig),
      .b      (cand_arr[k]),
      .sum    (acc[k])
    );
  end

  // One compare step: the first step seeds from SEED_IDX; replace only on strictly less.
  always_comb begin
    cand_sad_c = '0;
    for (int k = 0; k < int'(NCAND); k++) begin
      if (cmp_idx == 4'(k)) cand_sad_c = acc[k];
    end
    base_sad_c = cur_sad;
    base_idx_c = cur_idx;
    if (cmp_idx == 4'd0) begin
      base_sad_c = acc[SEED_IDX];
      base_idx_c = SEED_IDX;
    end
    nxt_sad_c = base_sad_c;
    nxt_idx_c = base_idx_c;
    if (cand_sad_c < base_sad_c) begin
      nxt_sad_c = cand_sad_c;
      nxt_idx_c = cmp_idx;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      sample_cnt <= '0;
      cmp_idx    <= '0;
      cur_idx    <= '0;
      cur_sad    <= '0;
      best_idx   <= '0;
      best_sad   <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else if (enable) begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            sample_cnt <= '0;
            state      <= ST_ACCUM;
            busy       <= 1'b1;
          end
        end
        ST_ACCUM: begin
          if (in_valid) begin
            sample_cnt <= sample_cnt + CNTW'(1);
            if (sample_cnt == CNTW'(NSAMPLES - 1)) begin
              state   <= ST_COMPARE;
              cmp_idx <= '0;
            end
          end
        end
        ST_COMPARE: begin
          cur_sad <= nxt_sad_c;
          cur_idx <= nxt_idx_c;
          cmp_idx <= cmp_idx + 4'd1;
          if (cmp_idx == 4'(NCAND - 1)) begin
            best_sad <= nxt_sad_c;
            best_idx <= nxt_idx_c;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_DONE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sad_best_candidate.sv
// Directed self-checking bench for sad_best_candidate (default parameters).
module tb_sad_best_candidate;

  localparam int unsigned DW = 8;
  localparam int unsigned SW = 14;

  logic          clock;
  logic          reset;
  logic          enable;
  logic          start;
  logic          in_valid;
  logic [DW-1:0] orig;
  logic [DW-1:0] cand [9];
  logic [3:0]    best_idx;
  logic [SW-1:0] best_sad;
  logic          done;
  logic          busy;

  int passed;
  int total;

  sad_best_candidate dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .start    (start),
    .in_valid (in_valid),
    .orig     (orig),
    .cand_0   (cand[0]),
    .cand_1   (cand[1]),
    .cand_2   (cand[2]),
    .cand_3   (cand[3]),
    .cand_4   (cand[4]),
    .cand_5   (cand[5]),
    .cand_6   (cand[6]),
    .cand_7   (cand[7]),
    .cand_8   (cand[8]),
    .best_idx (best_idx),
    .best_sad (best_sad),
    .done     (done),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string         name;
    logic [DW-1:0] orig;
    logic [DW-1:0] cand [9];
    int            exp_idx;
    int            exp_sad;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_pix(input logic [DW-1:0] o, input int d0, input int dk, input int kk);
    orig = o;
    for (int k = 0; k < 9; k++) cand[k] = DW'(int'(o) + ((k == kk) ? dk : d0));
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits for done after the last sample's edge; returns edges counted (lat) from the sample's cycle.
  task automatic wait_done(input int first, output int lat);
    lat = first;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  int lat;
  int seen;
  int edges;

  initial begin
    passed = 0;
    total = 0;
    reset = 1'b1; enable = 1'b1; start = 1'b0; in_valid = 1'b0;
    orig = '0;
    for (int k = 0; k < 9; k++) cand[k] = '0;

    vecs[0].name = "ramp";    vecs[0].orig = 8'd10;
    for (int k = 0; k < 9; k++) vecs[0].cand[k] = 8'(10 + k);
    vecs[0].exp_idx = 0; vecs[0].exp_sad = 0;
    vecs[1].name = "cand3";   vecs[1].orig = 8'd50;
    for (int k = 0; k < 9; k++) vecs[1].cand[k] = (k == 3) ? 8'd50 : 8'd51;
    vecs[1].exp_idx = 3; vecs[1].exp_sad = 0;
    vecs[2].name = "tie";     vecs[2].orig = 8'd100;
    for (int k = 0; k < 9; k++) vecs[2].cand[k] = 8'd102;
`ifdef FME_CENTER_BIAS_EN
    vecs[2].exp_idx = 4;
`else
    vecs[2].exp_idx = 0;
`endif
    vecs[2].exp_sad = 128;
    vecs[3].name = "maxsad";  vecs[3].orig = 8'd0;
    for (int k = 0; k < 9; k++) vecs[3].cand[k] = 8'd255;
    vecs[3].exp_idx = 0; vecs[3].exp_sad = 16320;

    tick(); tick();
    reset = 1'b0;
    check("rst_best_idx", int'(best_idx), 0);
    check("rst_best_sad", int'(best_sad), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);

    // Table-driven full blocks.
    for (int v = 0; v < 4; v++) begin
      do_start();
      check({vecs[v].name, "_busy"}, int'(busy), 1);
      orig = vecs[v].orig;
      for (int k = 0; k < 9; k++) cand[k] = vecs[v].cand[k];
      for (int s = 0; s < 64; s++) begin
        in_valid = 1'b1;
        tick();
      end
      in_valid = 1'b0;
      wait_done(1, lat);
      check({vecs[v].name, "_latency"}, lat, 10);
      check({vecs[v].name, "_idx"}, int'(best_idx), vecs[v].exp_idx);
      check({vecs[v].name, "_sad"}, int'(best_sad), vecs[v].exp_sad);
      tick();
      check({vecs[v].name, "_done_pulse"}, int'(done), 0);
      check({vecs[v].name, "_hold_sad"}, int'(best_sad), vecs[v].exp_sad);
      tick();
    end

    // Reset mid-block discards partial sums and never pulses done.
    do_start();
    set_pix(8'd20, 0, 90, 3);
    for (int s = 0; s < 30; s++) begin
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", int'(busy), 0);
    check("midrst_best_sad", int'(best_sad), 0);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) seen++;
      tick();
    end
    check("midrst_no_done", seen, 0);
    do_start();
    set_pix(8'd20, 1, 0, 3);
    for (int s = 0; s < 64; s++) begin
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    wait_done(1, lat);
    check("postrst_latency", lat, 10);
    check("postrst_idx", int'(best_idx), 3);
    check("postrst_sad", int'(best_sad), 0);
    tick(); tick();

    // enable low for 5 cycles mid-ACCUM: those samples (which would favour candidate 0) are dropped.
    do_start();
    edges = 0;
    set_pix(8'd40, 1, 0, 3);
    for (int s = 0; s < 20; s++) begin
      in_valid = 1'b1;
      tick();
      edges++;
    end
    enable = 1'b0;
    set_pix(8'd40, 0, 60, 3);
    for (int s = 0; s < 5; s++) begin
      tick();
      edges++;
    end
    check("hold_busy", int'(busy), 1);
    enable = 1'b1;
    set_pix(8'd40, 1, 0, 3);
    for (int s = 0; s < 44; s++) begin
      tick();
      edges++;
    end
    in_valid = 1'b0;
    wait_done(1, lat);
    edges = edges + lat - 1;
    check("en_latency", lat, 10);
    check("en_total_edges", edges, 78);
    check("en_idx", int'(best_idx), 3);
    check("en_sad", int'(best_sad), 0);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
